// File: rtl/mosquito_pkg.sv
// Shared constants for the mosquito sprite renderer: screen size, sprite size,
// texel codes, RGB444 palette and the two 16x16 sprite bitmaps.
package mosquito_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int SPRITE_SIZE = 16;

   typedef enum logic [1:0] {
      TEX_CLEAR = 2'd0,
      TEX_BODY  = 2'd1,
      TEX_WING  = 2'd2,
      TEX_EYE   = 2'd3
   } texel_e;

   localparam logic [11:0] RGB_BODY = 12'h432;
   localparam logic [11:0] RGB_WING = 12'hADF;
   localparam logic [11:0] RGB_EYE  = 12'hF00;

   // One row per word; column 0 sits in the two most significant bits.
   function automatic logic [31:0] sprite_row(input logic phase, input logic [3:0] row);
      logic [31:0] r;
      r = '0;
      if (!phase) begin
         case (row)
            4'd1:    r = 32'h0A0000A0;
            4'd2:    r = 32'h2A8002A8;
            4'd3:    r = 32'h2AA00AA8;
            4'd4:    r = 32'h0AA82AA0;
            4'd5:    r = 32'h00A96A00;
            4'd6:    r = 32'h00055000;
            4'd7:    r = 32'h00355C00;
            4'd8:    r = 32'h00055000;
            4'd9:    r = 32'h00014000;
            4'd10:   r = 32'h00014000;
            4'd11:   r = 32'h00041000;
            4'd12:   r = 32'h00100400;
            4'd13:   r = 32'h00400100;
            default: r = '0;
         endcase
      end else begin
         case (row)
            4'd5:    r = 32'h00055000;
            4'd6:    r = 32'h00055000;
            4'd7:    r = 32'h00355C00;
            4'd8:    r = 32'h0AA55AA0;
            4'd9:    r = 32'h2AA96AA8;
            4'd10:   r = 32'h2AA14AA8;
            4'd11:   r = 32'h0A8412A0;
            4'd12:   r = 32'h00100400;
            4'd13:   r = 32'h00400100;
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // addr = {flap_phase, row[3:0], col[3:0]}
   function automatic logic [1:0] sprite_texel(input logic [8:0] addr);
      logic [31:0] r;
      r = sprite_row(addr[8], addr[7:4]);
      return r[{~addr[3:0], 1'b0} +: 2];
   endfunction

   function automatic logic [11:0] texel_rgb(input logic [1:0] t);
      logic [11:0] c;
      case (t)
         TEX_BODY: c = RGB_BODY;
         TEX_WING: c = RGB_WING;
         TEX_EYE:  c = RGB_EYE;
         default:  c = 12'h000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mosquito_sprite_rom.sv
// Synchronous-read sprite ROM: address {flap_phase, row, col}, 2-bit texel,
// one cycle of read latency.
module mosquito_sprite_rom
   import mosquito_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [8:0] addr_i,
   output logic [1:0] data_o
);

   logic [1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q <= '0;
      end else begin
         data_q <= sprite_texel(addr_i);
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/mosquito_sprite_renderer.sv
// Two-stage sprite renderer for NUM_MOSQ mosquito slots with per-frame shadow
// registers. Define MOSQUITO_FLAP_EN to enable the frame counter and wing-flap bitmap.
module mosquito_sprite_renderer
   import mosquito_pkg::*;
#(
   parameter int  NUM_MOSQ    = 2,
   parameter int  COORD_W     = 10,
   parameter int  SPRITE_SIZE = mosquito_pkg::SPRITE_SIZE,
   parameter int  FLAP_FRAMES = 8,
   localparam int ID_W        = (NUM_MOSQ > 1) ? $clog2(NUM_MOSQ) : 1
) (
   input  logic                        clk25,
   input  logic                        reset_n,
   input  logic                        frame_start,
   input  logic                        video_on,
   input  logic [COORD_W-1:0]          pixel_x,
   input  logic [COORD_W-1:0]          pixel_y,
   input  logic [NUM_MOSQ*COORD_W-1:0] mosquito_x_flat,
   input  logic [NUM_MOSQ*COORD_W-1:0] mosquito_y_flat,
   input  logic [NUM_MOSQ-1:0]         mosquito_alive_flat,
   output logic                        pixel_on,
   output logic [11:0]                 pixel_rgb,
   output logic [ID_W-1:0]             pixel_id
);

   localparam int DW = COORD_W + 1;

   // ---------------- shadow registers ----------------
   logic [NUM_MOSQ*COORD_W-1:0] shadow_x_q, shadow_y_q;
   logic [NUM_MOSQ-1:0]         shadow_alive_q;

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         shadow_x_q     <= '0;
         shadow_y_q     <= '0;
         shadow_alive_q <= '0;
      end else if (frame_start) begin
         shadow_x_q     <= mosquito_x_flat;
         shadow_y_q     <= mosquito_y_flat;
         shadow_alive_q <= mosquito_alive_flat;
      end
   end

   // ---------------- wing-flap phase ----------------
   logic flap_phase;

`ifdef MOSQUITO_FLAP_EN
   localparam int CNT_W = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;

   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             flap_q, flap_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      flap_d      = flap_q;
      if (frame_start) begin
         if (frame_cnt_q == CNT_W'(FLAP_FRAMES - 1)) begin
            frame_cnt_d = '0;
            flap_d      = ~flap_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= '0;
         flap_q      <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         flap_q      <= flap_d;
      end
   end

   assign flap_phase = flap_q;
`else
   assign flap_phase = 1'b0;
`endif

   // ---------------- stage 1: range compare and ROM address ----------------
   logic [NUM_MOSQ-1:0][DW-1:0] dx, dy;
   logic [NUM_MOSQ-1:0][8:0]    rom_addr;
   logic [NUM_MOSQ-1:0]         cover_d, cover_q;
   logic                        visible_d, visible_q;

   // The extra top bit of dx/dy is the borrow: a pixel left of or above the
   // sprite origin can never alias into the sprite window.
   always_comb begin
      for (int i = 0; i < NUM_MOSQ; i++) begin
         dx[i]       = {1'b0, pixel_x} - {1'b0, shadow_x_q[i*COORD_W +: COORD_W]};
         dy[i]       = {1'b0, pixel_y} - {1'b0, shadow_y_q[i*COORD_W +: COORD_W]};
         cover_d[i]  = shadow_alive_q[i]
                       && !dx[i][COORD_W] && !dy[i][COORD_W]
                       && (dx[i] < DW'(SPRITE_SIZE)) && (dy[i] < DW'(SPRITE_SIZE));
         rom_addr[i] = {flap_phase, dy[i][3:0], dx[i][3:0]};
      end
   end

   assign visible_d = video_on
                      && (32'(pixel_x) < 32'(SCREEN_W))
                      && (32'(pixel_y) < 32'(SCREEN_H));

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         cover_q   <= '0;
         visible_q <= 1'b0;
      end else begin
         cover_q   <= cover_d;
         visible_q <= visible_d;
      end
   end

   logic [NUM_MOSQ-1:0][1:0] texel;

   for (genvar g = 0; g < NUM_MOSQ; g++) begin : g_rom
      mosquito_sprite_rom u_rom (
         .clk_i   (clk25),
         .rst_n_i (reset_n),
         .addr_i  (rom_addr[g]),
         .data_o  (texel[g])
      );
   end

   // ---------------- stage 2: priority and palette ----------------
   logic            hit_d, pixel_on_q;
   logic [ID_W-1:0] id_d, pixel_id_q;
   logic [1:0]      tex_d;
   logic [11:0]     rgb_d, pixel_rgb_q;

   // Walk from the highest slot down so the lowest opaque slot is the last writer.
   always_comb begin
      hit_d = 1'b0;
      id_d  = '0;
      tex_d = TEX_CLEAR;
      for (int i = NUM_MOSQ - 1; i >= 0; i--) begin
         if (visible_q && cover_q[i] && (texel[i] != TEX_CLEAR)) begin
            hit_d = 1'b1;
            id_d  = ID_W'(i);
            tex_d = texel[i];
         end
      end
      rgb_d = hit_d ? texel_rgb(tex_d) : 12'h000;
   end

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         pixel_on_q  <= 1'b0;
         pixel_rgb_q <= '0;
         pixel_id_q  <= '0;
      end else begin
         pixel_on_q  <= hit_d;
         pixel_rgb_q <= rgb_d;
         pixel_id_q  <= id_d;
      end
   end

   assign pixel_on  = pixel_on_q;
   assign pixel_rgb = pixel_rgb_q;
   assign pixel_id  = pixel_id_q;

endmodule

// File: tb/tb_mosquito_sprite_renderer.sv
// Self-checking bench for mosquito_sprite_renderer: randomized raster stimulus
// against a behavioural sprite model, plus hand-computed pixel probes.
`timescale 1ns/1ps
module tb_mosquito_sprite_renderer;

   localparam int NUM_MOSQ = 2;
   localparam int COORD_W  = 10;
   localparam int ID_W     = 1;
   localparam int W        = 1 + 12 + ID_W;

   // ---------------- clock / reset / DUT ----------------
   logic                        clk25 = 1'b0;
   logic                        reset_n = 1'b0;
   logic                        frame_start = 1'b0;
   logic                        video_on = 1'b0;
   logic [COORD_W-1:0]          pixel_x = '0;
   logic [COORD_W-1:0]          pixel_y = '0;
   logic [NUM_MOSQ*COORD_W-1:0] mx_flat = '0;
   logic [NUM_MOSQ*COORD_W-1:0] my_flat = '0;
   logic [NUM_MOSQ-1:0]         alive_flat = '0;
   logic                        pixel_on;
   logic [11:0]                 pixel_rgb;
   logic [ID_W-1:0]             pixel_id;

   always #20 clk25 = ~clk25;

   mosquito_sprite_renderer #(
      .NUM_MOSQ    (NUM_MOSQ),
      .COORD_W     (COORD_W),
      .SPRITE_SIZE (16),
      .FLAP_FRAMES (8)
   ) dut (
      .clk25               (clk25),
      .reset_n             (reset_n),
      .frame_start         (frame_start),
      .video_on            (video_on),
      .pixel_x             (pixel_x),
      .pixel_y             (pixel_y),
      .mosquito_x_flat     (mx_flat),
      .mosquito_y_flat     (my_flat),
      .mosquito_alive_flat (alive_flat),
      .pixel_on            (pixel_on),
      .pixel_rgb           (pixel_rgb),
      .pixel_id            (pixel_id)
   );

   // ---------------- behavioural model ----------------
   // '.' transparent, 'b' body, 'w' wing, 'e' eye
   string bm0 [16] = '{
      "................", "..ww........ww..", ".wwww......wwww.", ".wwwww....wwwww.",
      "..wwwww..wwwww..", "....wwwbbwww....", "......bbbb......", ".....ebbbbe.....",
      "......bbbb......", ".......bb.......", ".......bb.......", "......b..b......",
      ".....b....b.....", "....b......b....", "................", "................"};
   string bm1 [16] = '{
      "................", "................", "................", "................",
      "................", "......bbbb......", "......bbbb......", ".....ebbbbe.....",
      "..wwwwbbbbwwww..", ".wwwwwwbbwwwwww.", ".wwwww.bb.wwwww.", "..www.b..b.www..",
      ".....b....b.....", "....b......b....", "................", "................"};

   int sh_x [NUM_MOSQ];
   int sh_y [NUM_MOSQ];
   int sh_a [NUM_MOSQ];
   int m_phase = 0;
   int m_cnt   = 0;

   function automatic int texel(input int phase, input int row, input int col);
      string s;
      byte   c;
      s = (phase != 0) ? bm1[row] : bm0[row];
      c = s[col];
      case (c)
         "b":     return 1;
         "w":     return 2;
         "e":     return 3;
         default: return 0;
      endcase
   endfunction

   function automatic logic [11:0] pal(input int t);
      case (t)
         1:       return 12'h432;
         2:       return 12'hADF;
         3:       return 12'hF00;
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [W-1:0] px_word(input bit on, input logic [11:0] rgb, input int id);
      return {on, rgb, ID_W'(id)};
   endfunction

   function automatic logic [W-1:0] model_pixel(input int px, input int py, input bit v);
      logic [W-1:0] r;
      bit           found;
      int           t;
      r     = '0;
      found = 1'b0;
      if (v && px < 640 && py < 480) begin
         for (int i = 0; i < NUM_MOSQ; i++) begin
            if (!found && sh_a[i] != 0 && px >= sh_x[i] && px < sh_x[i] + 16
                && py >= sh_y[i] && py < sh_y[i] + 16) begin
               t = texel(m_phase, py - sh_y[i], px - sh_x[i]);
               if (t != 0) begin
                  found = 1'b1;
                  r     = px_word(1'b1, pal(t), i);
               end
            end
         end
      end
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   int vectors     = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q [$];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got on=%0b rgb=%03h id=%0d, expected on=%0b rgb=%03h id=%0d",
                  name, $time, got[W-1], got[W-2 -: 12], got[ID_W-1:0],
                  exp[W-1], exp[W-2 -: 12], exp[ID_W-1:0]);
      end
   endtask

   // Expected value is computed when the pixel is sampled and compared two edges later.
   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(posedge clk25);
         if (!reset_n) begin
            for (int i = 0; i < NUM_MOSQ; i++) begin
               sh_x[i] = 0; sh_y[i] = 0; sh_a[i] = 0;
            end
            m_phase = 0;
            m_cnt   = 0;
            e       = '0;
         end else begin
            e = model_pixel(int'(pixel_x), int'(pixel_y), video_on);
            if (frame_start) begin
               for (int i = 0; i < NUM_MOSQ; i++) begin
                  sh_x[i] = int'(mx_flat[i*COORD_W +: COORD_W]);
                  sh_y[i] = int'(my_flat[i*COORD_W +: COORD_W]);
                  sh_a[i] = int'(alive_flat[i]);
               end
`ifdef MOSQUITO_FLAP_EN
               if (m_cnt == 7) begin
                  m_cnt   = 0;
                  m_phase = 1 - m_phase;
               end else begin
                  m_cnt = m_cnt + 1;
               end
`endif
            end
         end
         exp_q.push_back(e);
         @(negedge clk25);
         if (!reset_n) begin
            exp_q.delete();
            check("reset_hold", {pixel_on, pixel_rgb, pixel_id}, '0);
         end else if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            check("pipeline", {pixel_on, pixel_rgb, pixel_id}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input int x, input int y, input bit v, input bit fs);
      @(posedge clk25);
      #1;
      pixel_x     = COORD_W'(x);
      pixel_y     = COORD_W'(y);
      video_on    = v;
      frame_start = fs;
   endtask

   task automatic set_slot(input int i, input int x, input int y, input bit a);
      mx_flat[i*COORD_W +: COORD_W] = COORD_W'(x);
      my_flat[i*COORD_W +: COORD_W] = COORD_W'(y);
      alive_flat[i]                 = a;
   endtask

   task automatic frame_pulse();
      drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
   endtask

   task automatic scan(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            drive(x, y, 1'b1, 1'b0);
   endtask

   // Presents one pixel, checks the model and the DUT output two edges later.
   task automatic probe(input string name, input int x, input int y, input logic [W-1:0] exp);
      check({name, "_model"}, model_pixel(x, y, 1'b1), exp);
      drive(x, y, 1'b1, 1'b0);
      @(posedge clk25);
      @(posedge clk25);
      @(negedge clk25);
      check(name, {pixel_on, pixel_rgb, pixel_id}, exp);
   endtask

   localparam logic [11:0] BODY = 12'h432;
   localparam logic [11:0] WING = 12'hADF;
   localparam logic [11:0] EYE  = 12'hF00;

   initial begin : watchdog
      #4_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int bx, by;
      repeat (4) @(posedge clk25);
      #1;
      check("reset_outputs", {pixel_on, pixel_rgb, pixel_id}, '0);
      reset_n = 1'b1;

      // Single sprite, full window scan
      set_slot(0, 200, 100, 1'b1);
      set_slot(1, 0, 0, 1'b0);
      frame_pulse();
      scan(198, 217, 99, 116);
      probe("s0_body", 207, 106, px_word(1'b1, BODY, 0));
      probe("s0_eye",  205, 107, px_word(1'b1, EYE, 0));
      probe("s0_clear", 201, 101, '0);
      probe("s0_wing", 202, 101, px_word(1'b1, WING, 0));
      probe("s0_right_edge", 216, 106, '0);

      // Overlap priority
      set_slot(0, 300, 50, 1'b1);
      set_slot(1, 308, 50, 1'b1);
      frame_pulse();
      probe("overlap_low_wins", 310, 55, px_word(1'b1, WING, 0));
      probe("overlap_see_through", 312, 55, px_word(1'b1, WING, 1));
      scan(296, 326, 48, 67);

      // Shadowing: input change without frame_start has no effect
      set_slot(0, 200, 100, 1'b1);
      set_slot(1, 0, 0, 1'b0);
      frame_pulse();
      set_slot(0, 210, 100, 1'b1);
      probe("shadow_old_hit", 207, 106, px_word(1'b1, BODY, 0));
      probe("shadow_old_miss", 217, 106, '0);
      scan(198, 228, 105, 107);
      frame_pulse();
      probe("shadow_new_hit", 217, 106, px_word(1'b1, BODY, 0));
      probe("shadow_new_miss", 207, 106, '0);

      // Clipping at the screen edge
      set_slot(0, 630, 470, 1'b1);
      frame_pulse();
      probe("clip_x_in", 639, 475, px_word(1'b1, WING, 0));
      probe("clip_x_out", 640, 475, '0);
      probe("clip_y_in", 637, 479, px_word(1'b1, BODY, 0));
      probe("clip_y_out", 637, 480, '0);
      scan(626, 647, 468, 487);

      // Borrow: no aliasing through coordinate wrap-around
      set_slot(0, 5, 0, 1'b1);
      set_slot(1, 1020, 0, 1'b1);
      frame_pulse();
      probe("borrow_slot1", 2, 5, '0);
      probe("far_right", 1000, 5, '0);
      probe("borrow_ctrl", 11, 5, px_word(1'b1, WING, 0));
      scan(0, 24, 0, 17);

      // Dead slot is never drawn
      set_slot(0, 200, 100, 1'b0);
      set_slot(1, 200, 100, 1'b0);
      frame_pulse();
      probe("dead_slot", 207, 106, '0);

      // Randomized frames against the model
      for (int f = 0; f < 24; f++) begin
         bx = int'($urandom_range(0, 1010));
         by = int'($urandom_range(0, 500));
         if (f % 3 == 0) begin
            bx = int'($urandom_range(560, 640));
            by = int'($urandom_range(400, 480));
         end
         for (int i = 0; i < NUM_MOSQ; i++)
            set_slot(i, (bx + int'($urandom_range(0, 20))) & 1023,
                     (by + int'($urandom_range(0, 20))) & 1023,
                     $urandom_range(0, 3) != 0);
         frame_pulse();
         for (int c = 0; c < 180; c++) begin
            if ($urandom_range(0, 59) == 0)
               set_slot(int'($urandom_range(0, NUM_MOSQ - 1)), int'($urandom_range(0, 1023)),
                        int'($urandom_range(0, 1023)), $urandom_range(0, 1) != 0);
            drive((bx + int'($urandom_range(0, 46)) - 6) & 1023,
                  (by + int'($urandom_range(0, 46)) - 6) & 1023,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
         end
      end

      // Mid-line reset: outputs clear at once, nothing drawn until frame_start
      set_slot(0, 200, 100, 1'b1);
      set_slot(1, 0, 0, 1'b0);
      frame_pulse();
      repeat (3) drive(207, 106, 1'b1, 1'b0);
      @(negedge clk25);
      check("pre_reset_drawn", {pixel_on, pixel_rgb, pixel_id}, px_word(1'b1, BODY, 0));
      @(posedge clk25);
      #1;
      reset_n = 1'b0;
      #1;
      check("reset_async", {pixel_on, pixel_rgb, pixel_id}, '0);
      repeat (3) drive(207, 106, 1'b1, 1'b0);
      reset_n = 1'b1;
      probe("post_reset_blank", 207, 106, '0);
      scan(198, 217, 104, 108);
      frame_pulse();
      probe("post_reset_frame", 207, 106, px_word(1'b1, BODY, 0));

`ifdef MOSQUITO_FLAP_EN
      // One pulse since reset: phase 0 until the eighth pulse
      probe("flap_phase0", 202, 108, '0);
      repeat (6) frame_pulse();
      probe("flap_cnt7", 202, 108, '0);
      frame_pulse();
      probe("flap_phase1", 202, 108, px_word(1'b1, WING, 0));
      probe("flap_phase1_body", 207, 105, px_word(1'b1, BODY, 0));
      scan(198, 217, 99, 116);
      repeat (8) frame_pulse();
      probe("flap_back0", 202, 108, '0);
      probe("flap_back0_wing", 202, 101, px_word(1'b1, WING, 0));
`endif

      repeat (4) drive(0, 0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
